// File: rtl/sbox_sched_pkg.sv
// Shared types for the byte-serial masked S-box scheduler: FSM states, byte
// index and the {valid, idx} tag that travels beside each in-flight byte.
package sbox_sched_pkg;

    localparam int NBYTES = 16;

    typedef logic [3:0] byte_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic      valid;
        byte_idx_t idx;
    } tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Fixed-latency tag shift register mirroring the external S-box pipeline.
// It never stalls, so a tag leaves exactly LAT cycles after it entered.
module sbox_tag_pipe
    import sbox_sched_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tag_vld,
    input  logic [3:0] tag_idx,
    output logic       ret_vld,
    output logic [3:0] ret_idx
);

    tag_t pipe [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: tag_vld, idx: tag_idx};
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign ret_vld = pipe[LAT-1].valid;
    assign ret_idx = pipe[LAT-1].idx;

endmodule

// File: rtl/sbox_byte_scheduler.sv
// Byte-serial scheduler feeding a two-share state through an external masked
// S-box pipeline. Optional SBOX_SHARE_REFRESH_EN remasks each issued byte pair.
module sbox_byte_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int RND_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       st0,
    input  logic [127:0]       st1,
`ifdef SBOX_SHARE_REFRESH_EN
    input  logic [RND_W+7:0]   rnd_in,
`else
    input  logic [RND_W-1:0]   rnd_in,
`endif
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic               sbox_vld,
    output logic [7:0]         sbox_in0,
    output logic [7:0]         sbox_in1,
    output logic [RND_W-1:0]   sbox_rnd,
    input  logic [7:0]         sbox_out0,
    input  logic [7:0]         sbox_out1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       so0,
    output logic [127:0]       so1
);

    state_t       state;
    state_t       state_nxt;
    byte_idx_t    issue_idx;
    logic [4:0]   done_cnt;
    logic [127:0] sh0;
    logic [127:0] sh1;
    logic [127:0] buf0;
    logic [127:0] buf1;
    logic         issue;
    logic         load;
    logic         ret_vld;
    logic [3:0]   ret_idx;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [7:0]   mask;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                issue = rnd_valid;
                if (rnd_valid && issue_idx == 4'(NBYTES - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (done_cnt == 5'(NBYTES)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load = in_valid & in_ready;

    // Each share is indexed on its own; the two never meet in this block.
    assign b0 = sh0[{issue_idx, 3'b000} +: 8];
    assign b1 = sh1[{issue_idx, 3'b000} +: 8];

`ifdef SBOX_SHARE_REFRESH_EN
    assign mask = rnd_in[RND_W+7:RND_W];
`else
    assign mask = 8'h00;
`endif

    // Outside an issue the S-box inputs sit at zero so stale shares never toggle them.
    assign sbox_in0  = issue ? (b0 ^ mask) : 8'h00;
    assign sbox_in1  = issue ? (b1 ^ mask) : 8'h00;
    assign sbox_vld  = issue;
    assign rnd_ready = issue;
    assign sbox_rnd  = rnd_in[RND_W-1:0];
    assign so0       = buf0;
    assign so1       = buf1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_idx <= '0;
            done_cnt  <= '0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                issue_idx <= '0;
                done_cnt  <= '0;
                buf0      <= '0;
                buf1      <= '0;
            end else begin
                if (issue) issue_idx <= issue_idx + 4'd1;
                if (ret_vld) begin
                    buf0[{ret_idx, 3'b000} +: 8] <= sbox_out0;
                    buf1[{ret_idx, 3'b000} +: 8] <= sbox_out1;
                    done_cnt <= done_cnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sh0 <= st0;
            sh1 <= st1;
        end
    end

    sbox_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_vld (issue),
        .tag_idx (issue_idx),
        .ret_vld (ret_vld),
        .ret_idx (ret_idx)
    );

endmodule

// File: tb/tb_sbox_byte_scheduler.sv
// Scoreboard bench for sbox_byte_scheduler with an ideal 3-cycle masked S-box
// model; honours SBOX_SHARE_REFRESH_EN when defined.
module tb_sbox_byte_scheduler;

    localparam int LAT   = 3;
    localparam int RND_W = 8;
`ifdef SBOX_SHARE_REFRESH_EN
    localparam int RIN_W   = RND_W + 8;
    localparam bit REFRESH = 1'b1;
`else
    localparam int RIN_W   = RND_W;
    localparam bit REFRESH = 1'b0;
`endif

    // Unshared state bytes 0..15 and their AES SubBytes images.
    localparam logic [127:0] ST_SEQ  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] EXP_SUB = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] ST1_RND = 128'h5a00c3e19f2b0077d46e1a0038b5f0c9;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     st0;
    logic [127:0]     st1;
    logic [RIN_W-1:0] rnd_in;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             sbox_vld;
    logic [7:0]       sbox_in0;
    logic [7:0]       sbox_in1;
    logic [RND_W-1:0] sbox_rnd;
    logic [7:0]       sbox_out0;
    logic [7:0]       sbox_out1;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     so0;
    logic [127:0]     so1;

    sbox_byte_scheduler #(
        .LAT   (LAT),
        .RND_W (RND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .st0       (st0),
        .st1       (st1),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sbox_vld  (sbox_vld),
        .sbox_in0  (sbox_in0),
        .sbox_in1  (sbox_in1),
        .sbox_rnd  (sbox_rnd),
        .sbox_out0 (sbox_out0),
        .sbox_out1 (sbox_out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .so0       (so0),
        .so1       (so1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sub_model(input logic [7:0] x);
        case (x)
            8'h00: return 8'h63; 8'h01: return 8'h7c; 8'h02: return 8'h77; 8'h03: return 8'h7b;
            8'h04: return 8'hf2; 8'h05: return 8'h6b; 8'h06: return 8'h6f; 8'h07: return 8'hc5;
            8'h08: return 8'h30; 8'h09: return 8'h01; 8'h0a: return 8'h67; 8'h0b: return 8'h2b;
            8'h0c: return 8'hfe; 8'h0d: return 8'hd7; 8'h0e: return 8'hab; 8'h0f: return 8'h76;
            default: return 8'h00;
        endcase
    endfunction

    // Ideal masked S-box: result reshared with the forwarded randomness.
    logic [7:0] m0 [LAT];
    logic [7:0] m1 [LAT];
    always @(posedge clk) begin
        m0[0] <= sub_model(sbox_in0 ^ sbox_in1) ^ sbox_rnd[7:0];
        m1[0] <= sbox_rnd[7:0];
        for (int i = 1; i < LAT; i++) begin
            m0[i] <= m0[i-1];
            m1[i] <= m1[i-1];
        end
    end
    assign sbox_out0 = m0[LAT-1];
    assign sbox_out1 = m1[LAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [127:0] sb_q [$];
    logic [127:0] cur0;
    logic [127:0] cur1;
    int           issue_cnt = 0;
    logic [7:0]   mon_e0;
    logic [7:0]   mon_e1;

    // Monitor: checks every issued byte and every released result.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (in_valid && in_ready) issue_cnt = 0;
            if (sbox_vld) begin
                if (issue_cnt < 16) begin
                    mon_e0 = cur0[issue_cnt*8 +: 8] ^ (REFRESH ? 8'hA5 : 8'h00);
                    mon_e1 = cur1[issue_cnt*8 +: 8] ^ (REFRESH ? 8'hA5 : 8'h00);
                    check("issue_in0", 128'(sbox_in0), 128'(mon_e0));
                    check("issue_in1", 128'(sbox_in1), 128'(mon_e1));
                end else begin
                    check("issue_overrun", 128'(issue_cnt), 128'(15));
                end
                issue_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("result_unexpected", 128'(1), 128'(0));
                else check("result_unshared", so0 ^ so1, sb_q.pop_front());
            end
        end
    end

    task automatic drive_rnd();
`ifdef SBOX_SHARE_REFRESH_EN
        rnd_in = {8'hA5, 8'($urandom)};
`else
        rnd_in = 8'($urandom);
`endif
    endtask

    task automatic run_load(input logic [127:0] s0, input logic [127:0] s1,
                            input logic [31:0] bubbles, input int exp_lat,
                            input logic [31:0] exp_vld, input int rst_rel,
                            input bit hold_done, input string tag);
        int           c0;
        int           lat;
        int           rel;
        logic [31:0]  vld_pat;
        logic [127:0] h0;
        logic [127:0] h1;
        bit           ok;
        @(negedge clk);
        cur0      = s0;
        cur1      = s1;
        st0       = s0;
        st1       = s1;
        in_valid  = 1'b1;
        out_ready = !hold_done;
        rnd_valid = 1'b1;
        drive_rnd();
        @(posedge clk);
        #1;
        c0       = cyc;
        in_valid = 1'b0;
        sb_q.push_back(EXP_SUB);
        lat      = -1;
        vld_pat  = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            rel       = cyc - c0;
            rnd_valid = (rel < 32) ? !bubbles[rel] : 1'b1;
            drive_rnd();
            if (rel == rst_rel) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_out_valid"}, 128'(out_valid), 128'(0));
                sb_q.delete();
                @(negedge clk);
                rst = 1'b0;
                #1;
                check({tag, "_rst_next_out_valid"}, 128'(out_valid), 128'(0));
                check({tag, "_rst_next_in_ready"}, 128'(in_ready), 128'(1));
                return;
            end
            #1;
            if (rel < 32) vld_pat[rel] = sbox_vld;
            if (out_valid) begin
                lat = rel;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_vld_pattern"}, 128'(vld_pat), 128'(exp_vld));
        if (hold_done) begin
            h0       = so0;
            h1       = so1;
            in_valid = 1'b1;
            ok       = 1'b1;
            repeat (5) begin
                @(negedge clk);
                #1;
                if (so0 !== h0 || so1 !== h1 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
            end
            check({tag, "_hold_stable"}, 128'(ok), 128'(1));
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        check({tag, "_back_to_idle"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        st0       = '0;
        st1       = '0;
        rnd_in    = '0;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        cur0      = '0;
        cur1      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready",  128'(in_ready),  128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_rnd_ready", 128'(rnd_ready), 128'(0));
        check("reset_sbox_vld",  128'(sbox_vld),  128'(0));
        check("reset_sbox_in",   128'({sbox_in0, sbox_in1}), 128'(0));
        check("reset_so0", so0, 128'(0));
        check("reset_so1", so1, 128'(0));
        @(negedge clk);
        rst = 1'b0;

        run_load(ST_SEQ, 128'(0), 32'h0, 20, 32'h0000FFFF, -1, 1'b0, "plain");
        run_load(ST_SEQ, 128'(0), 32'h00000218, 23, 32'h0007FDE7, -1, 1'b0, "bubbles");
        run_load(ST_SEQ ^ ST1_RND, ST1_RND, 32'h0, 20, 32'h0000FFFF, -1, 1'b0, "shared");
        run_load(ST_SEQ ^ ST1_RND, ST1_RND, 32'h0, 20, 32'h0000FFFF, 18, 1'b0, "drain_rst");
        run_load(ST_SEQ, 128'(0), 32'h0, 20, 32'h0000FFFF, -1, 1'b0, "after_rst");
        run_load(ST_SEQ ^ ST1_RND, ST1_RND, 32'h0, 20, 32'h0000FFFF, -1, 1'b1, "hold");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
